// File: rtl/spi_bridge_master.sv
// SPI mode-0 master: stream bytes go out MSB-first on MOSI; MISO bytes return as one-cycle rx_valid pulses.
// rx_valid comes 1+16*CLK_DIV cycles after acceptance; tx_ready is low while a byte shifts; rx cannot stall.
`timescale 1ns/1ps
module spi_bridge_master #(
   parameter int CLK_DIV  = 4,
   parameter int GAP_MULT = 2
) (
   input  logic       clk_clk,
   input  logic       reset_reset_n,
   input  logic [7:0] tx_data,
   input  logic       tx_last,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       busy,
   output logic       spi_sclk,
   output logic       spi_mosi,
   input  logic       spi_miso,
   output logic       spi_nss
);

   localparam logic [7:0] HALF_LAST = 8'(CLK_DIV - 1);
   localparam logic [3:0] GAP_LAST  = 4'(GAP_MULT - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_LOW, S_HIGH, S_WAIT_NEXT, S_HOLD, S_GAP
   } state_t;

   state_t     r_state, w_state_nxt;
   logic [7:0] r_cnt;
   logic [2:0] r_bit;
   logic [3:0] r_gap;
   logic [7:0] r_shift, r_rx, r_rx_data;
   logic       r_last, r_rx_vld;
   logic       r_miso_meta, r_miso_sync;
   logic       w_accept, w_shift_in, w_cnt_zero, w_reload;

   assign w_cnt_zero = (r_cnt == 8'd0);
   assign rx_data    = r_rx_data;
   assign rx_valid   = r_rx_vld;

   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) r_state <= S_IDLE;
      else                r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_shift_in  = 1'b0;
      tx_ready    = 1'b0;
      busy        = 1'b1;
      spi_nss     = 1'b0;
      spi_sclk    = 1'b0;
      spi_mosi    = r_shift[7];
      case (r_state)
         S_IDLE: begin
            tx_ready = 1'b1;
            busy     = 1'b0;
            spi_nss  = 1'b1;
            spi_mosi = 1'b0;
            if (tx_valid) begin
               w_accept    = 1'b1;
               w_state_nxt = S_LOW;
            end
         end
         S_LOW: if (w_cnt_zero) w_state_nxt = S_HIGH;
         S_HIGH: begin
            spi_sclk = 1'b1;
            if (w_cnt_zero) begin
               w_shift_in = 1'b1;
               if (r_bit == 3'd7) w_state_nxt = r_last ? S_HOLD : S_WAIT_NEXT;
               else               w_state_nxt = S_LOW;
            end
         end
         S_WAIT_NEXT: begin
            tx_ready = 1'b1;
            if (tx_valid) begin
               w_accept    = 1'b1;
               w_state_nxt = S_LOW;
            end
         end
         S_HOLD: if (w_cnt_zero) w_state_nxt = S_GAP;
         S_GAP: begin
            spi_nss  = 1'b1;
            spi_mosi = 1'b0;
            if (w_cnt_zero && (r_gap == GAP_LAST)) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // GAP is counted as GAP_MULT back-to-back half-periods, so the timer reloads inside it too
   assign w_reload = (r_state != w_state_nxt) || ((r_state == S_GAP) && w_cnt_zero);

   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         r_cnt       <= 8'd0;
         r_bit       <= 3'd0;
         r_gap       <= 4'd0;
         r_shift     <= 8'd0;
         r_rx        <= 8'd0;
         r_rx_data   <= 8'd0;
         r_rx_vld    <= 1'b0;
         r_last      <= 1'b0;
         r_miso_meta <= 1'b0;
         r_miso_sync <= 1'b0;
      end else begin
         r_miso_meta <= spi_miso;
         r_miso_sync <= r_miso_meta;
         r_rx_vld    <= 1'b0;
         if (w_reload)        r_cnt <= HALF_LAST;
         else if (!w_cnt_zero) r_cnt <= r_cnt - 8'd1;
         if (r_state != S_GAP) r_gap <= 4'd0;
         else if (w_cnt_zero)  r_gap <= r_gap + 4'd1;
         if (w_accept) begin
            r_shift <= tx_data;
            r_last  <= tx_last;
            r_bit   <= 3'd0;
         end
         if (w_shift_in) begin
            r_rx <= {r_rx[6:0], r_miso_sync};
            if (r_bit == 3'd7) begin
               r_rx_data <= {r_rx[6:0], r_miso_sync};
               r_rx_vld  <= 1'b1;
            end else begin
               r_bit   <= r_bit + 3'd1;
               r_shift <= {r_shift[6:0], 1'b0};
            end
         end
      end
   end

endmodule

// File: tb/tb_spi_bridge_master.sv
// Bench for spi_bridge_master: scoreboard of expected MOSI/MISO bytes and edge counts, plus cycle-exact waveform checks.
`timescale 1ns/1ps
module tb_spi_bridge_master;
   localparam int H = 4, G = 2, H3 = 3, G3 = 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic [7:0] tx_data, tx_data3, rx_data, rx_data3;
   logic       tx_last, tx_last3, tx_valid, tx_valid3;
   logic       tx_ready, tx_ready3, rx_valid, rx_valid3, busy, busy3;
   logic       spi_sclk, sclk3, spi_mosi, mosi3, spi_miso, spi_nss, nss3;
   logic       loop_en;
   logic       slv_bit = 1'b0;

   assign spi_miso = loop_en ? spi_mosi : slv_bit;

   spi_bridge_master #(.CLK_DIV(H), .GAP_MULT(G)) u_dut (
      .clk_clk(clk), .reset_reset_n(rst_n), .tx_data(tx_data), .tx_last(tx_last),
      .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
      .busy(busy), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_nss(spi_nss));

   spi_bridge_master #(.CLK_DIV(H3), .GAP_MULT(G3)) u_dut3 (
      .clk_clk(clk), .reset_reset_n(rst_n), .tx_data(tx_data3), .tx_last(tx_last3),
      .tx_valid(tx_valid3), .tx_ready(tx_ready3), .rx_data(rx_data3), .rx_valid(rx_valid3),
      .busy(busy3), .spi_sclk(sclk3), .spi_mosi(mosi3), .spi_miso(mosi3), .spi_nss(nss3));

   int n_tests = 0, n_fail = 0;
   int edge_cnt = 0;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   task automatic check(input bit ok, input string name, input int act, input int exp);
      n_tests++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Mode-0 slave: presents MSB on NSS fall, advances one bit per SCLK fall
   logic [7:0] slv_resp [4];
   int         slv_falls = 0;
   logic       nss_q = 1'b1;
   logic [7:0] slv_tmp;
   always @(negedge spi_nss or posedge spi_nss or negedge spi_sclk) begin
      if (spi_nss || nss_q) slv_falls = 0;
      else                  slv_falls++;
      nss_q   = spi_nss;
      slv_tmp = slv_resp[2'((slv_falls / 8) % 4)];
      slv_bit = slv_tmp[3'(7 - (slv_falls % 8))];
   end

   int         exp_rx[$], exp_tx[$], exp_edges[$];
   int         hi_len = 0, lo_len = 0, edges = 0, nbits = 0, e;
   logic [7:0] sh = 8'd0;
   bit         aborted = 1'b1;
   logic       p_sclk = 1'b0, p_nss = 1'b1;

   always @(negedge clk) begin
      if (!rst_n) begin
         exp_rx.delete(); exp_tx.delete(); exp_edges.delete();
         nbits = 0; edges = 0; aborted = 1'b1; hi_len = 0; lo_len = 0;
      end else begin
         if (rx_valid) begin
            if (exp_rx.size() == 0) check(1'b0, "rx_unexpected", int'(rx_data), -1);
            else begin
               e = exp_rx.pop_front();
               check(int'(rx_data) == e, "rx_data", int'(rx_data), e);
            end
         end
         if (!spi_nss && p_nss) begin
            edges = 0; nbits = 0; lo_len = 0; hi_len = 0; aborted = 1'b0;
         end
         if (spi_sclk && !p_sclk) begin
            if (!aborted && edges > 0) begin
               if (edges % 8 != 0) check(lo_len == H, "sclk_low_width", lo_len, H);
               else                check(lo_len >= H + 1, "interbyte_low_width", lo_len, H + 1);
            end
            edges++;
            sh = {sh[6:0], spi_mosi};
            nbits++;
            if (nbits == 8) begin
               nbits = 0;
               if (exp_tx.size() == 0) check(1'b0, "mosi_unexpected", int'(sh), -1);
               else begin
                  e = exp_tx.pop_front();
                  check(int'(sh) == e, "mosi_byte", int'(sh), e);
               end
            end
            lo_len = 0;
         end
         if (!spi_sclk && p_sclk) begin
            if (!aborted) check(hi_len == H, "sclk_high_width", hi_len, H);
            hi_len = 0;
         end
         if (spi_sclk) hi_len++;
         else          lo_len++;
         if (spi_nss && !p_nss && !aborted) begin
            if (exp_edges.size() == 0) check(1'b0, "frame_unexpected", edges, -1);
            else begin
               e = exp_edges.pop_front();
               check(edges == e, "frame_rising_edges", edges, e);
            end
         end
      end
      p_sclk = spi_sclk;
      p_nss  = spi_nss;
   end

   task automatic send(input bit sel, input logic [7:0] d, input bit last, input int exp, output int acc);
      bit got = 1'b0;
      acc = 0;
      @(posedge clk); #1;
      if (sel) begin tx_valid3 = 1'b1; tx_data3 = d; tx_last3 = last; end
      else     begin tx_valid  = 1'b1; tx_data  = d; tx_last  = last; end
      for (int i = 0; i < 3000 && !got; i++) begin
         @(negedge clk);
         if (sel ? tx_ready3 : tx_ready) begin
            got = 1'b1;
            acc = edge_cnt + 1;
         end
      end
      if (!got) check(1'b0, "accept_timeout", 0, 1);
      @(posedge clk); #1;
      tx_valid = 1'b0; tx_valid3 = 1'b0;
      if (got && !sel) begin
         exp_tx.push_back(int'(d));
         exp_rx.push_back(exp);
      end
   endtask

   task automatic wait_idle();
      int i;
      for (i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (!busy && tx_ready) break;
      end
      check(i < 3000, "idle_timeout", i, 3000);
   endtask

   // Cycle-by-cycle waveform of a looped single last-byte frame, cycle 1 = first cycle after acceptance
   task automatic check_single(input bit sel, input logic [7:0] d, input int h, input int g);
      int t = 1 + 16 * h;
      int n = t + h + g * h + 1;
      int b_sclk = 0, b_nss = 0, b_mosi = 0, b_rv = 0, b_rdy = 0, b_busy = 0, b_rd = 0;
      int ph;
      logic e_sclk, e_nss, e_mosi, e_rdy;
      for (int c = 1; c <= n; c++) begin
         @(negedge clk);
         ph     = (c - 1) / h;
         e_sclk = (ph < 16) && (ph % 2 == 1);
         e_nss  = (c > t + h - 1);
         if (c <= 16 * h)       e_mosi = d[3'(7 - (c - 1) / (2 * h))];
         else if (c <= t + h - 1) e_mosi = d[0];
         else                   e_mosi = 1'b0;
         e_rdy  = (c >= t + h + g * h);
         if ((sel ? sclk3 : spi_sclk) !== e_sclk) b_sclk++;
         if ((sel ? nss3 : spi_nss) !== e_nss) b_nss++;
         if ((sel ? mosi3 : spi_mosi) !== e_mosi) b_mosi++;
         if ((sel ? rx_valid3 : rx_valid) !== (c == t)) b_rv++;
         if ((sel ? tx_ready3 : tx_ready) !== e_rdy) b_rdy++;
         if ((sel ? busy3 : busy) !== !e_rdy) b_busy++;
         if (c == t && (sel ? rx_data3 : rx_data) !== d) b_rd++;
      end
      check(b_sclk == 0, "wave_sclk_bad_cycles", b_sclk, 0);
      check(b_nss == 0, "wave_nss_bad_cycles", b_nss, 0);
      check(b_mosi == 0, "wave_mosi_bad_cycles", b_mosi, 0);
      check(b_rv == 0, "wave_rx_valid_bad_cycles", b_rv, 0);
      check(b_rdy == 0, "wave_tx_ready_bad_cycles", b_rdy, 0);
      check(b_busy == 0, "wave_busy_bad_cycles", b_busy, 0);
      check(b_rd == 0, "wave_rx_data", b_rd, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1);
   end

   initial begin
      int acc, bad, rises, len, gap;
      logic ps;
      logic [7:0] d;
      rst_n = 1'b0; tx_valid = 1'b1; tx_data = 8'hA5; tx_last = 1'b0;
      tx_valid3 = 1'b0; tx_data3 = 8'h00; tx_last3 = 1'b0; loop_en = 1'b1;
      for (int i = 0; i < 4; i++) slv_resp[i] = 8'h00;

      // Reset held 3 cycles with tx_valid high
      bad = 0;
      repeat (3) begin
         @(posedge clk); @(negedge clk);
         if (spi_sclk || !spi_nss) bad++;
      end
      check(bad == 0, "reset_sclk_activity", bad, 0);
      check(spi_nss == 1'b1, "reset_nss", int'(spi_nss), 1);
      check(spi_sclk == 1'b0, "reset_sclk", int'(spi_sclk), 0);
      check(spi_mosi == 1'b0, "reset_mosi", int'(spi_mosi), 0);
      check(tx_ready == 1'b1, "reset_tx_ready", int'(tx_ready), 1);
      check(rx_valid == 1'b0, "reset_rx_valid", int'(rx_valid), 0);
      check(rx_data == 8'h00, "reset_rx_data", int'(rx_data), 0);
      check(busy == 1'b0, "reset_busy", int'(busy), 0);
      @(posedge clk); #1;
      tx_valid = 1'b0; rst_n = 1'b1;

      // Single looped byte, exact timing
      exp_edges.push_back(8);
      send(1'b0, 8'hA5, 1'b1, 32'hA5, acc);
      check_single(1'b0, 8'hA5, H, G);

      // Two-byte frame against the slave model
      loop_en = 1'b0; slv_resp[0] = 8'h5A; slv_resp[1] = 8'h96;
      exp_edges.push_back(16);
      send(1'b0, 8'h3C, 1'b0, 32'h5A, acc);
      send(1'b0, 8'hC3, 1'b1, 32'h96, acc);
      wait_idle();

      // Stall in WAIT_NEXT for 100 cycles
      loop_en = 1'b1;
      exp_edges.push_back(16);
      send(1'b0, 8'h5A, 1'b0, 32'h5A, acc);
      bad = 1;
      for (int i = 0; i < 2000 && bad != 0; i++) begin
         @(negedge clk);
         if (rx_valid) bad = 0;
      end
      check(bad == 0, "stall_rx_timeout", bad, 0);
      repeat (100) begin
         @(negedge clk);
         if (spi_nss || spi_sclk || !tx_ready || !busy) bad++;
      end
      check(bad == 0, "stall_unstable_cycles", bad, 0);
      send(1'b0, 8'h11, 1'b1, 32'h11, acc);
      wait_idle();

      // Reset after the 3rd SCLK rise
      exp_edges.push_back(8);
      send(1'b0, 8'h96, 1'b1, 32'h96, acc);
      rises = 0; ps = spi_sclk;
      for (int i = 0; i < 2000 && rises < 3; i++) begin
         @(negedge clk);
         if (spi_sclk && !ps) rises++;
         ps = spi_sclk;
      end
      check(rises == 3, "abort_rise_timeout", rises, 3);
      @(posedge clk); #1; rst_n = 1'b0;
      @(posedge clk); #1; rst_n = 1'b1;
      @(negedge clk);
      check(spi_nss == 1'b1, "abort_nss", int'(spi_nss), 1);
      check(spi_sclk == 1'b0, "abort_sclk", int'(spi_sclk), 0);
      bad = 0;
      repeat (150) begin
         @(negedge clk);
         if (rx_valid) bad++;
      end
      check(bad == 0, "abort_rx_valid_pulses", bad, 0);
      exp_edges.push_back(8);
      send(1'b0, 8'hFF, 1'b1, 32'hFF, acc);
      wait_idle();

      // CLK_DIV=3, GAP_MULT=1 instance
      send(1'b1, 8'h81, 1'b1, 0, acc);
      check_single(1'b1, 8'h81, H3, G3);

      // Randomized frames, looped or slave-driven, with random inter-byte stalls
      for (int f = 0; f < 10; f++) begin
         len = $urandom_range(1, 3);
         loop_en = 1'($urandom_range(0, 1));
         for (int i = 0; i < 4; i++) slv_resp[i] = 8'($urandom);
         exp_edges.push_back(8 * len);
         for (int i = 0; i < len; i++) begin
            gap = $urandom_range(0, 6);
            repeat (gap) @(posedge clk);
            d = 8'($urandom);
            send(1'b0, d, i == len - 1, loop_en ? int'(d) : int'(slv_resp[i]), acc);
         end
         wait_idle();
      end

      repeat (5) @(negedge clk);
      check(exp_rx.size() == 0, "rx_left_over", exp_rx.size(), 0);
      check(exp_tx.size() == 0, "mosi_left_over", exp_tx.size(), 0);
      check(exp_edges.size() == 0, "frames_left_over", exp_edges.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
